// File: rtl/bus_memory_loader.sv
// bus_memory_loader
//   Owns the main memory array and shares it between two masters under the
//   control of a mode FSM driven by op:
//     - user load port: burst writes through an auto-incrementing pointer
//       (lptr), plus 1-cycle-latency reads; active in IDLE/LOAD.
//     - CPU bus port: reads and writes, active only in RUN.
//   A one-cycle DRAIN state follows RUN so that a CPU read issued in the last
//   RUN cycle still completes. Two sticky error flags are cleared on entry to
//   LOAD.
//
// Ports:
//   clk, reset (async, active low)
//   op                                 mode request: 0 load/program, 1 run
//   user_addr_set, user_addr           pointer load / user read address
//   user_wr_valid, user_wr_ready,
//   user_data                          user write handshake
//   user_rd_en, user_rd_data,
//   user_rd_valid                      user read
//   cpu_req, cpu_we, cpu_addr,
//   cpu_wdata, cpu_rdata, cpu_rvalid   CPU bus access
//   lptr                               current load pointer
//   mode                               00 IDLE, 01 LOAD, 10 RUN, 11 DRAIN
//   wr_err                             sticky: user write outside LOAD
//   addr_err                           sticky: access to an address >= DEPTH
module bus_memory_loader #(
    parameter int DW    = 8,
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          op,
    input  logic          user_addr_set,
    input  logic [AW-1:0] user_addr,
    input  logic          user_wr_valid,
    output logic          user_wr_ready,
    input  logic [DW-1:0] user_data,
    input  logic          user_rd_en,
    output logic [DW-1:0] user_rd_data,
    output logic          user_rd_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    output logic [AW-1:0] lptr,
    output logic [1:0]    mode,
    output logic          wr_err,
    output logic          addr_err
);

    // Index width into the array; address bits above it only matter for the
    // range check, which guards every access.
    localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        RUN   = 2'b10,
        DRAIN = 2'b11
    } mode_t;

    logic [DW-1:0] mem [DEPTH];

    mode_t         mode_reg, mode_next;
    logic [AW-1:0] lptr_reg, lptr_next;
    logic          wr_err_reg, wr_err_next;
    logic          addr_err_reg, addr_err_next;
    logic [DW-1:0] user_rd_data_reg;
    logic          user_rd_valid_reg;
    logic [DW-1:0] cpu_rdata_reg;
    logic          cpu_rvalid_reg;

    logic          is_load, is_run, user_side;
    logic          lptr_ok, user_addr_ok, cpu_addr_ok;
    logic          user_wr_fire, user_wr_do, user_rd_fire;
    logic          cpu_rd_fire, cpu_wr_do;
    logic          mem_we;
    logic [IW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          enter_load;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    always_comb begin
        is_load      = (mode_reg == LOAD);
        is_run       = (mode_reg == RUN);
        user_side    = (mode_reg == IDLE) || (mode_reg == LOAD);
        lptr_ok      = in_range(lptr_reg);
        user_addr_ok = in_range(user_addr);
        cpu_addr_ok  = in_range(cpu_addr);

        user_wr_fire = is_load && user_wr_valid;
        user_wr_do   = user_wr_fire && lptr_ok;
        user_rd_fire = user_side && user_rd_en;
        cpu_rd_fire  = is_run && cpu_req && !cpu_we;
        cpu_wr_do    = is_run && cpu_req && cpu_we && cpu_addr_ok;

        // Only one master can own the write port in any given mode.
        mem_we    = user_wr_do || cpu_wr_do;
        mem_waddr = is_load ? lptr_reg[IW-1:0] : cpu_addr[IW-1:0];
        mem_wdata = is_load ? user_data : cpu_wdata;

        mode_next = mode_reg;
        case (mode_reg)
            IDLE:    mode_next = op ? RUN : LOAD;
            LOAD:    if (op) mode_next = RUN;
            RUN:     if (!op) mode_next = DRAIN;
            default: mode_next = LOAD;
        endcase

        // Pointer load beats the post-write increment; the write itself
        // still lands at the old pointer.
        lptr_next = lptr_reg;
        if (is_load && user_addr_set) begin
            lptr_next = user_addr;
        end else if (user_wr_do) begin
            lptr_next = (lptr_reg == LAST) ? '0 : lptr_reg + AW'(1);
        end

        // Clearing on entry to LOAD wins over any error raised in the
        // same cycle: that error belongs to the session being left.
        enter_load    = (mode_next == LOAD) && (mode_reg != LOAD);
        wr_err_next   = wr_err_reg || (user_wr_valid && !is_load);
        addr_err_next = addr_err_reg
                      || (user_rd_fire && !user_addr_ok)
                      || (user_wr_fire && !lptr_ok)
                      || (is_run && cpu_req && !cpu_addr_ok);
        if (enter_load) begin
            wr_err_next   = 1'b0;
            addr_err_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_reg          <= IDLE;
            lptr_reg          <= '0;
            wr_err_reg        <= 1'b0;
            addr_err_reg      <= 1'b0;
            user_rd_data_reg  <= '0;
            user_rd_valid_reg <= 1'b0;
            cpu_rdata_reg     <= '0;
            cpu_rvalid_reg    <= 1'b0;
        end else begin
            mode_reg          <= mode_next;
            lptr_reg          <= lptr_next;
            wr_err_reg        <= wr_err_next;
            addr_err_reg      <= addr_err_next;
            user_rd_valid_reg <= user_rd_fire;
            cpu_rvalid_reg    <= cpu_rd_fire;
            // Reads sample the array before this edge's write: old data on
            // a same-address collision.
            if (user_rd_fire) begin
                user_rd_data_reg <= user_addr_ok ? mem[user_addr[IW-1:0]] : '0;
            end
            if (cpu_rd_fire) begin
                cpu_rdata_reg <= cpu_addr_ok ? mem[cpu_addr[IW-1:0]] : '0;
            end
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign user_wr_ready = is_load;
    assign user_rd_data  = user_rd_data_reg;
    assign user_rd_valid = user_rd_valid_reg;
    assign cpu_rdata     = cpu_rdata_reg;
    assign cpu_rvalid    = cpu_rvalid_reg;
    assign lptr          = lptr_reg;
    assign mode          = mode_reg;
    assign wr_err        = wr_err_reg;
    assign addr_err      = addr_err_reg;

endmodule
